// File: rtl/dmem_io_bridge_if.sv
// Data-memory bus between the core's memory stage and dmem_io_bridge.
// The core drives address, data and strobe; the bridge returns combinational load data.
interface dmem_io_bridge_if;
  logic        memwrite;
  logic [31:0] alu_out;
  logic [31:0] write_data;
  logic [31:0] data_read;

  modport master (
    output memwrite,
    output alu_out,
    output write_data,
    input  data_read
  );

  modport slave (
    input  memwrite,
    input  alu_out,
    input  write_data,
    output data_read
  );
endinterface

// File: rtl/dmem_io_bridge.sv
// Data-side memory stage: word RAM plus memory-mapped LED, switch, timer and UART-TX registers.
// Loads are combinational for a single-cycle core; stores commit on the rising edge.
module dmem_io_bridge #(
  parameter int DEPTH   = 256,
  parameter int LED_W   = 16,
  parameter int SW_W    = 16,
  parameter int CLK_DIV = 868
) (
  input  logic              clk,
  input  logic              rst,
  dmem_io_bridge_if.slave   bus,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out,
  output logic              uart_tx
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  logic [31:0]      mem [DEPTH];
  logic [LED_W-1:0] led_r;
  logic [SW_W-1:0]  sync1_r;
  logic [SW_W-1:0]  sync2_r;
  logic [31:0]      timer_r;

  uart_state_t      state_r;
  logic             busy_r;
  logic             tx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;
  logic [7:0]       byte_r;

  logic [29:0]      word_s;
  logic [5:0]       off_s;
  logic             io_sel_s;
  logic             ram_sel_s;
  logic             wr_ram_s;
  logic             wr_led_s;
  logic             wr_tmr_s;
  logic             wr_uart_s;
  logic             cnt_last_s;
  logic [31:0]      rd_s;
  logic             unused_s;

  // Byte offset bits carry no meaning on a word-addressed bus.
  assign unused_s   = ^bus.alu_out[1:0];

  assign word_s     = bus.alu_out[31:2];
  assign off_s      = bus.alu_out[7:2];
  assign io_sel_s   = (bus.alu_out[31:8] == 24'h0000FF);
  assign ram_sel_s  = !io_sel_s && ({2'b00, word_s} < 32'(DEPTH));
  assign wr_ram_s   = bus.memwrite && ram_sel_s;
  assign wr_led_s   = bus.memwrite && io_sel_s && (off_s == 6'd0);
  assign wr_tmr_s   = bus.memwrite && io_sel_s && (off_s == 6'd2);
  assign wr_uart_s  = bus.memwrite && io_sel_s && (off_s == 6'd3);
  assign cnt_last_s = (cnt_r == CNT_LAST);

  // Load data mux over RAM and IO registers.
  always_comb begin
    rd_s = 32'h0000_0000;
    if (io_sel_s) begin
      case (off_s)
        6'd0:    rd_s = 32'(led_r);
        6'd1:    rd_s = 32'(sync2_r);
        6'd2:    rd_s = timer_r;
        6'd3:    rd_s = {31'h0000_0000, busy_r};
        default: rd_s = 32'h0000_0000;
      endcase
    end else if (ram_sel_s) begin
      rd_s = mem[word_s[AW-1:0]];
    end else begin
      rd_s = 32'h0000_0000;
    end
  end

  assign bus.data_read = rd_s;
  assign led_out       = led_r;
  assign uart_tx       = tx_r;

  // Data RAM word store; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ram_s) begin
      mem[word_s[AW-1:0]] <= bus.write_data;
    end
  end

  // LED register, switch synchroniser and free-running timer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      led_r   <= '0;
      sync1_r <= '0;
      sync2_r <= '0;
      timer_r <= 32'h0000_0000;
    end else begin
      sync1_r <= sw_in;
      sync2_r <= sync1_r;
      if (wr_led_s) begin
        led_r <= bus.write_data[LED_W-1:0];
      end
      // A store clears the timer and overrides that cycle's increment.
      if (wr_tmr_s) begin
        timer_r <= 32'h0000_0000;
      end else begin
        timer_r <= timer_r + 32'h0000_0001;
      end
    end
  end

  // UART 8N1 transmitter FSM with registered line output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      tx_r    <= 1'b1;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      byte_r  <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          idx_r <= 3'd0;
          if (wr_uart_s) begin
            byte_r  <= bus.write_data[7:0];
            busy_r  <= 1'b1;
            tx_r    <= 1'b0;
            state_r <= START;
          end else begin
            busy_r <= 1'b0;
            tx_r   <= 1'b1;
          end
        end
        START: begin
          if (cnt_last_s) begin
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            tx_r    <= byte_r[0];
            state_r <= DATA;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_last_s) begin
            cnt_r <= '0;
            if (idx_r == 3'd7) begin
              tx_r    <= 1'b1;
              state_r <= STOP;
            end else begin
              idx_r <= idx_r + 3'd1;
              tx_r  <= byte_r[idx_r + 3'd1];
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_last_s) begin
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          tx_r    <= 1'b1;
          cnt_r   <= '0;
          idx_r   <= 3'd0;
        end
      endcase
    end
  end

endmodule
